// File: rtl/counter_pkg.sv
// counter_pkg
// Shared types for the flex counter chain: channel mode encoding, the
// ping-pong direction bit and the width of one channel's mode field.
// No ports; imported by flex_counter_chan and flex_counter_chain.
package counter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [1:0] {
    CM_UP       = 2'b00,
    CM_DOWN     = 2'b01,
    CM_PINGPONG = 2'b10,
    CM_HOLD     = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/flex_counter_chan.sv
// flex_counter_chan
// One channel of the cascaded counter. Owns the count register and the
// ping-pong direction register; produces a combinational carry for the next
// channel and the terminal-match of the next-state value for the flag regs.
//
// Ports:
//   clk, n_rst  clock, asynchronous active-low reset
//   en          advance this channel this cycle (count_enable or lower carry)
//   clear       synchronous reload of the start value, dominates en
//   lo, hi      lower / upper bound
//   step        increment magnitude, 0 behaves as 1 (assumes STEP_W <= SIZE)
//   mode        cnt_mode_e encoding
//   cnt         registered count
//   carry       combinational carry out (never set during clear)
//   term_next   next count equals the terminal value of the next mode/dir
module flex_counter_chan
  import counter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              en,
  input  logic              clear,
  input  logic [SIZE-1:0]   lo,
  input  logic [SIZE-1:0]   hi,
  input  logic [STEP_W-1:0] step,
  input  logic [MODE_W-1:0] mode,
  output logic [SIZE-1:0]   cnt,
  output logic              carry,
  output logic              term_next
);

  localparam int XW = SIZE + 1;

  logic [SIZE-1:0] cnt_q, cnt_d;
  cnt_dir_e        dir_q, dir_d;
  cnt_mode_e       mode_e;

  // Bound arithmetic is widened by one bit so cnt + step never wraps.
  logic [SIZE-1:0] s_n;
  logic [XW-1:0]   cnt_x, lo_x, hi_x, s_x, cnt_plus_s, lo_plus_s;
  logic [SIZE-1:0] cnt_minus_s, hi_minus_s;

  assign mode_e = cnt_mode_e'(mode);

  always_comb begin
    s_n         = (step == '0) ? SIZE'(1) : SIZE'(step);
    s_x         = {1'b0, s_n};
    cnt_x       = {1'b0, cnt_q};
    lo_x        = {1'b0, lo};
    hi_x        = {1'b0, hi};
    cnt_plus_s  = cnt_x + s_x;
    lo_plus_s   = lo_x + s_x;
    // Only used where the guards below prove no underflow.
    cnt_minus_s = cnt_q - s_n;
    hi_minus_s  = hi - s_n;
  end

  always_comb begin
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    carry     = 1'b0;
    term_next = 1'b0;

    if (clear) begin
      case (mode_e)
        CM_UP, CM_PINGPONG: cnt_d = lo;
        CM_DOWN:            cnt_d = hi;
        default:            cnt_d = cnt_q;
      endcase
      dir_d = DIR_UP;
    end else begin
      // Leaving ping-pong resets the sweep direction.
      if (mode_e != CM_PINGPONG) dir_d = DIR_UP;

      if (en) begin
        if (mode_e == CM_HOLD) begin
          carry = 1'b1;  // transparent: higher channels keep counting
        end else if (lo >= hi) begin
          // Degenerate or illegal window: park on lo, carry every enable.
          cnt_d = lo;
          carry = 1'b1;
          dir_d = DIR_UP;
        end else begin
          case (mode_e)
            CM_UP: begin
              if (cnt_x >= hi_x || cnt_plus_s > hi_x) begin
                cnt_d = lo;
                carry = 1'b1;
              end else begin
                cnt_d = cnt_plus_s[SIZE-1:0];
              end
            end
            CM_DOWN: begin
              if (cnt_x <= lo_x || cnt_x < lo_plus_s) begin
                cnt_d = hi;
                carry = 1'b1;
              end else begin
                cnt_d = cnt_minus_s;
              end
            end
            CM_PINGPONG: begin
              if (dir_q == DIR_UP) begin
                if (cnt_x >= hi_x) begin
                  dir_d = DIR_DOWN;
                  cnt_d = (hi_x < lo_plus_s) ? lo : hi_minus_s;
                end else begin
                  cnt_d = (cnt_plus_s > hi_x) ? hi : cnt_plus_s[SIZE-1:0];
                end
              end else begin
                if (cnt_x <= lo_x) begin
                  // Turning at the bottom completes one full sweep.
                  dir_d = DIR_UP;
                  carry = 1'b1;
                  cnt_d = (lo_plus_s > hi_x) ? hi : lo_plus_s[SIZE-1:0];
                end else begin
                  cnt_d = (cnt_x < lo_plus_s) ? lo : cnt_minus_s;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end

    case (mode_e)
      CM_UP:       term_next = (cnt_d == hi);
      CM_DOWN:     term_next = (cnt_d == lo);
      CM_PINGPONG: term_next = (dir_d == DIR_UP) ? (cnt_d == hi) : (cnt_d == lo);
      default:     term_next = (cnt_d == cnt_q);
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/flex_counter_chain.sv
// flex_counter_chain
// NUM_CH cascaded counters for raster/window address generation. Channel 0
// advances on count_enable, channel k on the carry of channel k-1; the whole
// carry chain settles within one cycle.
//
// Ports:
//   clk, n_rst    clock, asynchronous active-low reset
//   clear         synchronous reload of all channels, dominates count_enable
//   count_enable  advance channel 0
//   lo_val/hi_val per-channel bounds, channel k at [k*SIZE +: SIZE]
//   step          per-channel step, channel k at [k*STEP_W +: STEP_W]
//   mode          per-channel mode, channel k at [k*2 +: 2]
//   count_out     registered counts
//   wrap_flag     registered pulse: channel k carried on the last update
//   term_flag     registered level: channel k sits on its terminal value
//   done_flag     registered pulse: carry out of the last channel
module flex_counter_chain
  import counter_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int NUM_CH = 2,
  parameter int STEP_W = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     count_enable,
  input  logic [NUM_CH*SIZE-1:0]   lo_val,
  input  logic [NUM_CH*SIZE-1:0]   hi_val,
  input  logic [NUM_CH*STEP_W-1:0] step,
  input  logic [NUM_CH*MODE_W-1:0] mode,
  output logic [NUM_CH*SIZE-1:0]   count_out,
  output logic [NUM_CH-1:0]        wrap_flag,
  output logic [NUM_CH-1:0]        term_flag,
  output logic                     done_flag
);

  logic [NUM_CH-1:0] en, carry, term_next;
  logic [NUM_CH-1:0] wrap_q, wrap_d, term_q, term_d;
  logic              done_q, done_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    if (g == 0) begin : g_first
      assign en[g] = count_enable;
    end else begin : g_rest
      assign en[g] = carry[g-1];
    end

    flex_counter_chan #(
      .SIZE   (SIZE),
      .STEP_W (STEP_W)
    ) u_chan (
      .clk       (clk),
      .n_rst     (n_rst),
      .en        (en[g]),
      .clear     (clear),
      .lo        (lo_val[g*SIZE +: SIZE]),
      .hi        (hi_val[g*SIZE +: SIZE]),
      .step      (step[g*STEP_W +: STEP_W]),
      .mode      (mode[g*MODE_W +: MODE_W]),
      .cnt       (count_out[g*SIZE +: SIZE]),
      .carry     (carry[g]),
      .term_next (term_next[g])
    );
  end

  // Flags come from next-state values so they line up with count_out.
  always_comb begin
    wrap_d = clear ? '0 : carry;
    done_d = clear ? 1'b0 : carry[NUM_CH-1];
    term_d = term_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wrap_q <= '0;
      term_q <= '0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      term_q <= term_d;
      done_q <= done_d;
    end
  end

  assign wrap_flag = wrap_q;
  assign term_flag = term_q;
  assign done_flag = done_q;

endmodule

// File: tb/tb_flex_counter_chain.sv
// tb_flex_counter_chain
// Directed scan sequences followed by randomized configuration/enable/clear
// traffic, all checked every cycle against an integer model of the counting
// rules, plus literal expected sequences for the documented scans.
module tb_flex_counter_chain;

  localparam int SIZE   = 8;
  localparam int NUM_CH = 3;
  localparam int STEP_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic clear = 1'b0;
  logic count_enable = 1'b0;
  logic [NUM_CH*SIZE-1:0]   lo_val = '0;
  logic [NUM_CH*SIZE-1:0]   hi_val = '0;
  logic [NUM_CH*STEP_W-1:0] step = '0;
  logic [NUM_CH*2-1:0]      mode = '0;
  logic [NUM_CH*SIZE-1:0]   count_out;
  logic [NUM_CH-1:0]        wrap_flag;
  logic [NUM_CH-1:0]        term_flag;
  logic                     done_flag;

  always #5 clk = ~clk;

  flex_counter_chain #(
    .SIZE   (SIZE),
    .NUM_CH (NUM_CH),
    .STEP_W (STEP_W)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .lo_val       (lo_val),
    .hi_val       (hi_val),
    .step         (step),
    .mode         (mode),
    .count_out    (count_out),
    .wrap_flag    (wrap_flag),
    .term_flag    (term_flag),
    .done_flag    (done_flag)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [SIZE-1:0] exp_q[$];

  int   m_cnt  [NUM_CH];
  int   m_dir  [NUM_CH];  // 0 rising, 1 falling
  logic m_wrap [NUM_CH];
  logic m_term [NUM_CH];
  logic m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SIZE-1:0] ch(input int k);
    return count_out[k*SIZE +: SIZE];
  endfunction

  // ---------------- behavioural model ----------------
  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k] = 0; m_dir[k] = 0; m_wrap[k] = 0; m_term[k] = 0;
    end
    m_done = 0;
  endtask

  // One clock of the chain, from the rules on plain integers.
  task automatic model_step();
    int lo, hi, s, md, nx, c, en, tv;
    en = int'(count_enable);
    c = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      lo = int'(lo_val[k*SIZE +: SIZE]);
      hi = int'(hi_val[k*SIZE +: SIZE]);
      s  = int'(step[k*STEP_W +: STEP_W]);
      if (s == 0) s = 1;
      md = int'(mode[k*2 +: 2]);
      nx = m_cnt[k];
      c  = 0;
      if (clear) begin
        if (md == 0 || md == 2) nx = lo;
        else if (md == 1) nx = hi;
        m_dir[k] = 0;
      end else begin
        if (md != 2) m_dir[k] = 0;
        if (en != 0) begin
          if (md == 3) c = 1;
          else if (lo >= hi) begin nx = lo; c = 1; m_dir[k] = 0; end
          else if (md == 0) begin
            if (m_cnt[k] + s > hi) begin nx = lo; c = 1; end
            else nx = m_cnt[k] + s;
          end else if (md == 1) begin
            if (m_cnt[k] - s < lo) begin nx = hi; c = 1; end
            else nx = m_cnt[k] - s;
          end else if (m_dir[k] == 0) begin
            if (m_cnt[k] >= hi) begin
              m_dir[k] = 1;
              nx = (hi - s > lo) ? hi - s : lo;
            end else nx = (m_cnt[k] + s < hi) ? m_cnt[k] + s : hi;
          end else begin
            if (m_cnt[k] <= lo) begin
              m_dir[k] = 0; c = 1;
              nx = (lo + s < hi) ? lo + s : hi;
            end else nx = (m_cnt[k] - s > lo) ? m_cnt[k] - s : lo;
          end
        end
      end
      case (md)
        0:       tv = hi;
        1:       tv = lo;
        2:       tv = (m_dir[k] == 0) ? hi : lo;
        default: tv = m_cnt[k];
      endcase
      m_term[k] = (nx == tv);
      m_cnt[k]  = nx;
      m_wrap[k] = (c != 0);
      en = c;
    end
    m_done = (c != 0);
  endtask

  task automatic compare_all();
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("model_cnt%0d", k), ch(k), m_cnt[k]);
      chk($sformatf("model_wrap%0d", k), wrap_flag[k], m_wrap[k]);
      chk($sformatf("model_term%0d", k), term_flag[k], m_term[k]);
    end
    chk("model_done", done_flag, m_done);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_ch(input int k, input int lo, input int hi, input int st, input int md);
    lo_val[k*SIZE +: SIZE]   = SIZE'(lo);
    hi_val[k*SIZE +: SIZE]   = SIZE'(hi);
    step[k*STEP_W +: STEP_W] = STEP_W'(st);
    mode[k*2 +: 2]           = 2'(md);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input logic en, input logic clr);
    count_enable = en;
    clear = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  int done_cnt;
  int wexp[$];
  int texp[$];

  initial begin
    model_reset();
    @(negedge clk);
    compare_all();
    chk("reset_cnt0", ch(0), 0);
    chk("reset_flags", {wrap_flag, term_flag, done_flag}, 0);
    n_rst = 1'b1;

    // Raster: ch0 0..3, ch1 0..2, ch2 transparent hold.
    set_ch(0, 0, 3, 1, 0); set_ch(1, 0, 2, 1, 0); set_ch(2, 0, 0, 1, 3);
    tick(0, 1);
    chk("t1_clr_ch0", ch(0), 0);
    done_cnt = 0;
    for (int n = 1; n <= 24; n++) begin
      tick(1, 0);
      chk("t1_ch0", ch(0), n % 4);
      chk("t1_ch1", ch(1), (n / 4) % 3);
      chk("t1_wrap0", wrap_flag[0], (n % 4) == 0);
      chk("t1_done", done_flag, (n % 12) == 0);
      if (done_flag === 1'b1) done_cnt++;
    end
    chk("t1_done_count", done_cnt, 2);

    // Step overshoot and step 0.
    set_ch(0, 2, 9, 3, 0);
    tick(0, 1);
    chk("t2_clr", ch(0), 2);
    exp_q = '{5, 8, 2}; wexp = '{0, 0, 1};
    while (exp_q.size() > 0) begin
      tick(1, 0);
      chk("t2_ch0", ch(0), exp_q.pop_front());
      chk("t2_wrap0", wrap_flag[0], wexp.pop_front());
    end
    set_ch(0, 2, 9, 0, 0);
    tick(0, 1);
    exp_q = '{3, 4, 5};
    while (exp_q.size() > 0) begin
      tick(1, 0);
      chk("t2_step0", ch(0), exp_q.pop_front());
    end

    // Ping-pong.
    set_ch(0, 0, 4, 3, 2);
    tick(0, 1);
    chk("t3_clr", ch(0), 0);
    chk("t3_clr_term", term_flag[0], 0);
    exp_q = '{3, 4, 1, 0, 3}; texp = '{0, 1, 0, 1, 0}; wexp = '{0, 0, 0, 0, 1};
    while (exp_q.size() > 0) begin
      tick(1, 0);
      chk("t3_ch0", ch(0), exp_q.pop_front());
      chk("t3_term0", term_flag[0], texp.pop_front());
      chk("t3_wrap0", wrap_flag[0], wexp.pop_front());
    end

    // Down with a transparent middle channel.
    set_ch(0, 1, 5, 2, 1); set_ch(1, 6, 9, 1, 0); set_ch(2, 0, 1, 1, 0);
    tick(0, 1);
    set_ch(1, 0, 9, 1, 3);
    tick(0, 1);
    chk("t4_clr_ch0", ch(0), 5);
    chk("t4_hold_ch1", ch(1), 6);
    exp_q = '{3, 1, 5, 3, 1, 5}; wexp = '{0, 0, 1, 1, 1, 0}; texp = '{0, 0, 0, 0, 0, 1};
    while (exp_q.size() > 0) begin
      tick(1, 0);
      chk("t4_ch0", ch(0), exp_q.pop_front());
      chk("t4_ch1", ch(1), 6);
      chk("t4_ch2", ch(2), wexp.pop_front());
      chk("t4_done", done_flag, texp.pop_front());
    end

    // Clear together with enable, at a point where ch0 would wrap.
    tick(1, 0);
    tick(1, 0);
    chk("t5_pre", ch(0), 1);
    tick(1, 1);
    chk("t5_clr_ch0", ch(0), 5);
    chk("t5_clr_wrap", wrap_flag, 0);
    chk("t5_clr_done", done_flag, 0);

    // Asynchronous reset mid-run.
    tick(1, 0);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("t5_arst_cnt", count_out, 0);
    chk("t5_arst_flags", {wrap_flag, term_flag, done_flag}, 0);
    @(negedge clk);
    compare_all();
    n_rst = 1'b1;

    // Degenerate windows.
    set_ch(0, 7, 7, 1, 0);
    tick(0, 1);
    for (int n = 0; n < 3; n++) begin
      tick(1, 0);
      chk("t6_eq_ch0", ch(0), 7);
      chk("t6_eq_wrap", wrap_flag[0], 1);
    end
    set_ch(0, 9, 3, 1, 0);
    tick(0, 1);
    chk("t6_bad_clr", ch(0), 9);
    for (int n = 0; n < 3; n++) begin
      tick(1, 0);
      chk("t6_bad_ch0", ch(0), 9);
      chk("t6_bad_wrap", wrap_flag[0], 1);
      chk("t6_no_x", $isunknown({count_out, wrap_flag, term_flag, done_flag}), 0);
    end
    set_ch(0, 9, 3, 2, 1);
    tick(0, 1);
    tick(1, 0);
    tick(1, 0);

    // Randomized traffic, including bounds near the top of the range.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        int k;
        k = int'($urandom_range(0, NUM_CH - 1));
        if ($urandom_range(0, 3) == 0)
          set_ch(k, int'($urandom_range(230, 255)), int'($urandom_range(240, 255)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        else
          set_ch(k, int'($urandom_range(0, 20)), int'($urandom_range(0, 24)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flex_counter_chain.md
Name: flex_counter_chain

Overview:
Parametrised multi-channel cascaded counter for raster and window address generation, such as pixel x/y, pyramid-level scans and Bresenham-circle offset walks.
- NUM_CH channels form a carry chain: channel 0 advances on count_enable; channel k advances when channel k-1 carries.
- Each channel has its own lower bound, upper bound, step and mode.
- Mode set is up, down, ping-pong and hold/transparent.
- Registered per-channel wrap/terminal flags and a chain-done pulse drive the scan-control FSMs.

Parameters:
SIZE, 8, bit width of every channel count and bound
NUM_CH, 2, number of cascaded channels (1..8); channel 0 is least significant
STEP_W, 4, bit width of each channel step value

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
clear  in  1  synchronous re-initialise of all channels; priority over count_enable
count_enable  in  1  advance channel 0 this cycle
lo_val  in  NUM_CH*SIZE  per-channel lower bound, channel k at [k*SIZE +: SIZE]
hi_val  in  NUM_CH*SIZE  per-channel upper bound
step  in  NUM_CH*STEP_W  per-channel increment magnitude
mode  in  NUM_CH*2  per-channel mode: 00 UP, 01 DOWN, 10 PINGPONG, 11 HOLD
count_out  out  NUM_CH*SIZE  registered per-channel counts
wrap_flag  out  NUM_CH  registered one-cycle pulse: channel k carried out last cycle
term_flag  out  NUM_CH  registered level: channel k count equals its terminal value
done_flag  out  1  registered one-cycle pulse: carry out of channel NUM_CH-1

Behaviour:
- Reset (n_rst low, async):
  - all counts 0, all directions UP, wrap_flag 0, term_flag 0, done_flag 0.
- clear (synchronous, dominates count_enable):
  - each channel loads its start value: lo for UP/PINGPONG, hi for DOWN, unchanged for HOLD.
  - all directions become UP.
  - wrap_flag and done_flag are 0 next cycle.
  - term_flag is evaluated on the loaded values.
- Effective step s_eff = step, except step 0 is treated as 1.
- All bound arithmetic is done in SIZE+1 bits; there is no modulo wrap.
- Carry chain is combinational within one cycle:
  - en[0] = count_enable; en[k] = carry[k-1].
  - A channel with en=0 holds its value and has carry 0.
- UP, with en:
  - if cnt >= hi or cnt + s_eff > hi: next = lo, carry = 1.
  - else next = cnt + s_eff.
- DOWN, with en:
  - if cnt <= lo or cnt < lo + s_eff: next = hi, carry = 1.
  - else next = cnt - s_eff.
- PINGPONG, with en, uses a per-channel direction bit:
  - dir UP, cnt >= hi: dir becomes DOWN, next = max(hi - s_eff, lo), carry = 0.
  - dir UP, otherwise: next = min(cnt + s_eff, hi).
  - dir DOWN, cnt <= lo: dir becomes UP, next = min(lo + s_eff, hi), carry = 1 (one full sweep done).
  - dir DOWN, otherwise: next = max(cnt - s_eff, lo).
- HOLD:
  - count frozen; carry = en (transparent), so higher channels still advance.
- Degenerate bounds:
  - lo == hi: count stays at lo; every enable produces carry = 1.
  - lo > hi (illegal): next = lo and carry = 1 on every enable; no X and no lock-up.
- Out-of-range count after reprogramming bounds mid-run is resolved by the compare rules above: UP snaps to lo, DOWN snaps to hi. No extra cycle.
- Flags are computed from next-state values and registered, so they align with count_out:
  - wrap_flag[k] = carry[k].
  - done_flag = carry[NUM_CH-1].
  - term_flag[k] = (next == terminal), where terminal is hi for UP, lo for DOWN, hi when dir UP or lo when dir DOWN for PINGPONG, and current value for HOLD.
- Latency: count_out updates on the clock edge after count_enable is sampled high. There are no bubbles; the chain can advance every cycle.
- A mode change mid-run takes effect on the next enabled cycle. The direction bit is kept unless the new mode is not PINGPONG, in which case it is forced to UP.

Decomposition:
- Package counter_pkg:
  - typedef enum logic [1:0] cnt_mode_e {CM_UP, CM_DOWN, CM_PINGPONG, CM_HOLD}.
  - typedef enum logic cnt_dir_e {DIR_UP, DIR_DOWN}.
- Sub-module flex_counter_chan, one channel:
  - inputs: en, clear, lo, hi, step, mode.
  - outputs: cnt, carry (combinational), term_next.
  - owns the count and direction registers.
- Top level: generate loop over NUM_CH, carry wiring, flag registers.

Test Plan:
- NUM_CH=2, SIZE=8, ch0 UP lo=0 hi=3 step=1, ch1 UP lo=0 hi=2, enable held -> ch0 0,1,2,3,0...; ch1 increments on each ch0 wrap; done_flag pulses once every 12 enables; wrap_flag[0] high the cycle ch0 shows 0.
- ch0 UP lo=2 hi=9 step=3 -> 2,5,8,2 (8+3 > 9); wrap_flag[0] with the 2; step=0 -> counts 2,3,4... by 1.
- ch0 PINGPONG lo=0 hi=4 step=3 -> 0,3,4,1,0,3; term_flag[0] high at 4 and at 0 (DOWN); wrap_flag[0] only when leaving 0 in DOWN.
- ch0 DOWN lo=1 hi=5 step=2, ch1 HOLD, NUM_CH=3 with ch2 UP lo=0 hi=1 -> ch0 5,3,1,5; ch1 frozen; ch2 toggles on each ch0 wrap via transparent ch1.
- clear asserted together with count_enable mid-count -> counts load start values (DOWN channel loads hi), no wrap_flag or done_flag that cycle; n_rst pulsed mid-run -> all outputs 0 immediately, asynchronously.
- lo=hi=7 -> count 7 constant, wrap_flag[0] every enable; lo=9 hi=3 -> count 9, carry every enable, no X on any output.
